// File: rtl/dmem_seq.sv
// Data-memory sequencer: serialises core/external accesses onto one memory port.
// Optional RMW write-back sequence enabled by DMEM_RMW_EN.
module dmem_seq #(
    parameter int AW   = 8,
    parameter int DW   = 16,
    parameter int XMAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic          c_rmw,
    input  logic [3:0]    c_op,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          stall,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          x_req,
    input  logic          x_we,
    input  logic [AW-1:0] x_addr,
    input  logic [DW-1:0] x_wdata,
    output logic          x_gnt,
    output logic          x_rvalid,
    output logic [DW-1:0] x_rdata,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic [DW-1:0] al_a,
    output logic [DW-1:0] al_b,
    output logic [3:0]    al_op,
    input  logic [DW-1:0] al_y
);

    localparam int          XW     = $clog2(XMAX + 1);
    localparam logic [XW-1:0] XLIM = XW'(XMAX);
    localparam logic [3:0]  OP_THB = 4'b1111;

`ifdef DMEM_RMW_EN
    typedef enum logic [1:0] {S_IDLE, S_CRD, S_CRMW, S_XRD} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_CRD, S_XRD} state_e;
`endif

    state_e        state_q, state_d;
    logic [XW-1:0] xwait_q, xwait_d;
    logic          x_win;
    logic          rmw_hit;

`ifdef DMEM_RMW_EN
    assign rmw_hit = c_rmw & c_we;
`else
    assign rmw_hit = 1'b0;
    // RMW inputs have no function in this build
    logic unused_ok;
    assign unused_ok = ^{c_rmw, c_op, al_y};
`endif

    // Starved external port overrides the core once xwait saturates
    assign x_win = x_req & ((xwait_q == XLIM) | ~c_req);

    always_comb begin
        state_d  = state_q;
        xwait_d  = xwait_q;
        stall    = 1'b0;
        c_rvalid = 1'b0;
        c_rdata  = '0;
        x_gnt    = 1'b0;
        x_rvalid = 1'b0;
        x_rdata  = '0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        al_a     = '0;
        al_b     = '0;
        al_op    = OP_THB;

        case (state_q)
            S_IDLE: begin
                if (x_win) begin
                    x_gnt  = 1'b1;
                    m_addr = x_addr;
                    stall  = c_req;
                    if (x_we) begin
                        m_we    = 1'b1;
                        m_wdata = x_wdata;
                    end else begin
                        state_d = S_XRD;
                    end
                end else if (c_req) begin
                    m_addr = c_addr;
                    if (c_we && !rmw_hit) begin
                        m_we    = 1'b1;
                        m_wdata = c_wdata;
                    end else begin
                        stall = 1'b1;
`ifdef DMEM_RMW_EN
                        state_d = rmw_hit ? S_CRMW : S_CRD;
`else
                        state_d = S_CRD;
`endif
                    end
                end
            end
            S_CRD: begin
                c_rvalid = 1'b1;
                c_rdata  = m_rdata;
                state_d  = S_IDLE;
            end
`ifdef DMEM_RMW_EN
            S_CRMW: begin
                al_a    = m_rdata;
                al_b    = c_wdata;
                al_op   = c_op;
                m_we    = 1'b1;
                m_addr  = c_addr;
                m_wdata = al_y;
                state_d = S_IDLE;
            end
`endif
            S_XRD: begin
                x_rvalid = 1'b1;
                x_rdata  = m_rdata;
                stall    = c_req;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (x_gnt) begin
            xwait_d = '0;
        end else if (x_req && xwait_q != XLIM) begin
            xwait_d = xwait_q + XW'(1);
        end

        // Reset aborts any in-flight sequence in the same cycle
        if (rst) begin
            state_d  = S_IDLE;
            xwait_d  = '0;
            stall    = 1'b0;
            c_rvalid = 1'b0;
            c_rdata  = '0;
            x_gnt    = 1'b0;
            x_rvalid = 1'b0;
            x_rdata  = '0;
            m_we     = 1'b0;
            m_addr   = '0;
            m_wdata  = '0;
            al_a     = '0;
            al_b     = '0;
            al_op    = OP_THB;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            xwait_q <= '0;
        end else begin
            state_q <= state_d;
            xwait_q <= xwait_d;
        end
    end

endmodule

// File: tb/tb_dmem_seq.sv
// Directed bench for dmem_seq with a behavioural memory and ALU.
// Expected values follow DMEM_RMW_EN when it is defined.
module tb_dmem_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, c_rmw;
    logic [3:0]  c_op;
    logic [7:0]  c_addr;
    logic [15:0] c_wdata;
    logic        stall, c_rvalid;
    logic [15:0] c_rdata;
    logic        x_req, x_we;
    logic [7:0]  x_addr;
    logic [15:0] x_wdata;
    logic        x_gnt, x_rvalid;
    logic [15:0] x_rdata;
    logic        m_we;
    logic [7:0]  m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata;
    logic [15:0] al_a, al_b;
    logic [3:0]  al_op;
    logic [15:0] al_y;

    logic [15:0] mem [256];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_seq #(.AW(8), .DW(16), .XMAX(4)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_rmw(c_rmw), .c_op(c_op),
        .c_addr(c_addr), .c_wdata(c_wdata),
        .stall(stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata),
        .x_gnt(x_gnt), .x_rvalid(x_rvalid), .x_rdata(x_rdata),
        .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .al_a(al_a), .al_b(al_b), .al_op(al_op), .al_y(al_y)
    );

    always @(posedge clk) begin
        if (m_we) mem[m_addr] <= m_wdata;
        m_rdata <= mem[m_addr];
    end

    always_comb begin
        al_y = al_a;
        if (al_op == 4'b0000) al_y = al_a + al_b;
        else if (al_op == 4'b0001) al_y = al_a - al_b;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core(input logic r, input logic w, input logic m,
                        input logic [3:0] op, input logic [7:0] a,
                        input logic [15:0] d);
        c_req = r; c_we = w; c_rmw = m; c_op = op; c_addr = a; c_wdata = d;
    endtask

    task automatic ext(input logic r, input logic w, input logic [7:0] a,
                       input logic [15:0] d);
        x_req = r; x_we = w; x_addr = a; x_wdata = d;
    endtask

    initial begin
        logic [5:0]  eg;
        logic [5:0]  es;
        logic [15:0] rmw_exp;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        m_rdata = '0;
        rst = 1'b1;
        core(0, 0, 0, 4'h0, 8'h00, 16'h0000);
        ext(0, 0, 8'h00, 16'h0000);
        tick();
        tick();

        // reset state
        core(1, 1, 0, 4'h0, 8'h55, 16'hAAAA);
        #2;
        chk("rst_mwe", m_we, 0);
        chk("rst_stall", stall, 0);
        core(0, 0, 0, 4'h0, 8'h00, 16'h0000);
        rst = 1'b0;
        #2;
        chk("rst_maddr", m_addr, 0);
        chk("rst_mwdata", m_wdata, 0);
        chk("rst_xgnt", x_gnt, 0);
        chk("rst_crv", c_rvalid, 0);
        chk("rst_xrv", x_rvalid, 0);
        chk("rst_alop", al_op, 4'hF);
        chk("rst_xwait", dut.xwait_q, 0);
        tick();

        // simultaneous core store and external read, xwait=0
        core(1, 1, 0, 4'h0, 8'h50, 16'h7777);
        ext(1, 0, 8'h30, 16'h0000);
        #2;
        chk("sim_mwe", m_we, 1);
        chk("sim_maddr", m_addr, 8'h50);
        chk("sim_xgnt", x_gnt, 0);
        chk("sim_stall", stall, 0);
        tick();
        chk("sim_xwait1", dut.xwait_q, 1);
        core(0, 0, 0, 4'h0, 8'h00, 16'h0000);
        #2;
        chk("sim_xgnt2", x_gnt, 1);
        tick();
        ext(0, 0, 8'h00, 16'h0000);
        #2;
        chk("sim_xrv", x_rvalid, 1);
        chk("sim_xwait0", dut.xwait_q, 0);
        chk("sim_mem50", mem[8'h50], 16'h7777);
        tick();

        // core store then load
        core(1, 1, 0, 4'h0, 8'h10, 16'h1234);
        #2;
        chk("st_mwe", m_we, 1);
        chk("st_wdata", m_wdata, 16'h1234);
        chk("st_stall", stall, 0);
        tick();
        core(1, 0, 0, 4'h0, 8'h10, 16'h0000);
        #2;
        chk("ld_stall", stall, 1);
        chk("ld_mwe", m_we, 0);
        chk("ld_maddr", m_addr, 8'h10);
        tick();
        #2;
        chk("ld_rvalid", c_rvalid, 1);
        chk("ld_rdata", c_rdata, 16'h1234);
        chk("ld_stall2", stall, 0);
        tick();
        core(0, 0, 0, 4'h0, 8'h00, 16'h0000);
        #2;
        chk("ld_rv_off", c_rvalid, 0);
        chk("ld_mwe_off", m_we, 0);

        // RMW ADD on 0x20 holding 5, operand 3
        core(1, 1, 0, 4'h0, 8'h20, 16'h0005);
        tick();
        core(1, 1, 1, 4'h0, 8'h20, 16'h0003);
        #2;
`ifdef DMEM_RMW_EN
        rmw_exp = 16'h0008;
        chk("rmw_stall", stall, 1);
        chk("rmw_mwe0", m_we, 0);
        chk("rmw_maddr0", m_addr, 8'h20);
        tick();
        #2;
        chk("rmw_mwe1", m_we, 1);
        chk("rmw_ala", al_a, 16'h0005);
        chk("rmw_alb", al_b, 16'h0003);
        chk("rmw_wdata", m_wdata, 16'h0008);
        chk("rmw_stall1", stall, 0);
`else
        rmw_exp = 16'h0003;
        chk("rmw_stall", stall, 0);
        chk("rmw_mwe0", m_we, 1);
        chk("rmw_wdata", m_wdata, 16'h0003);
        chk("rmw_alop", al_op, 4'hF);
`endif
        tick();
        core(0, 0, 0, 4'h0, 8'h00, 16'h0000);
        #2;
        chk("rmw_mem", mem[8'h20], rmw_exp);
        tick();

        // continuous core loads versus held external write
        eg = 6'b010000;
        es = 6'b110101;
        core(1, 0, 0, 4'h0, 8'h10, 16'h0000);
        ext(1, 1, 8'h40, 16'h5555);
        for (int i = 0; i < 6; i++) begin
            #2;
            chk($sformatf("xs_gnt%0d", i), x_gnt, eg[i]);
            chk($sformatf("xs_stall%0d", i), stall, es[i]);
            if (i == 4) chk("xs_maddr", m_addr, 8'h40);
            tick();
        end
        chk("xs_xwait0", dut.xwait_q, 1);
        core(0, 0, 0, 4'h0, 8'h00, 16'h0000);
        ext(0, 0, 8'h00, 16'h0000);
        #2;
        chk("xs_mem40", mem[8'h40], 16'h5555);
        tick();

        // external write then read of 0x30
        ext(1, 1, 8'h30, 16'hBEEF);
        #2;
        chk("xw_gnt", x_gnt, 1);
        chk("xw_mwe", m_we, 1);
        chk("xw_wdata", m_wdata, 16'hBEEF);
        tick();
        ext(1, 0, 8'h30, 16'h0000);
        #2;
        chk("xr_gnt", x_gnt, 1);
        chk("xr_mwe", m_we, 0);
        tick();
        ext(0, 0, 8'h00, 16'h0000);
        core(1, 0, 0, 4'h0, 8'h30, 16'h0000);
        #2;
        chk("xr_rvalid", x_rvalid, 1);
        chk("xr_rdata", x_rdata, 16'hBEEF);
        chk("xr_cstall", stall, 1);
        chk("xr_gnt_off", x_gnt, 0);
        tick();
        #2;
        chk("xr_cld_stall", stall, 1);
        tick();
        #2;
        chk("xr_cld_data", c_rdata, 16'hBEEF);
        tick();
        core(0, 0, 0, 4'h0, 8'h00, 16'h0000);
        tick();

        // reset during the second cycle of an RMW/load sequence
        core(1, 1, 1, 4'h0, 8'h20, 16'h0003);
        tick();
        rst = 1'b1;
        #2;
        chk("ra_mwe", m_we, 0);
        chk("ra_crv", c_rvalid, 0);
        chk("ra_stall", stall, 0);
        tick();
        rst = 1'b0;
        core(0, 0, 0, 4'h0, 8'h00, 16'h0000);
        #2;
        chk("ra_mwe2", m_we, 0);
        chk("ra_crv2", c_rvalid, 0);
        chk("ra_maddr", m_addr, 0);
        chk("ra_alop", al_op, 4'hF);
        chk("ra_mem", mem[8'h20], rmw_exp);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/dmem_seq.md
# dmem_seq

Data-memory sequencer for the PU. Sits between the decoder/datapath (dmwe/dms-driven accesses) and the single-port synchronous data memory. It serialises core loads, stores and read-modify-write stores (SM [ra] = [ra op rb]) into legal memory cycles, drives the ALU during the RMW write-back, and shares the memory port with an external loader/debug port under a starvation-bounded priority scheme.

## Interface
- AW, 8: data-memory address width
- DW, 16: data width
- XMAX, 4: denied-cycle count after which the external port wins over the core
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- c_req  in  1  core access request; held stable while stall=1
- c_we  in  1  core store (1) / load (0)
- c_rmw  in  1  store is read-modify-write (valid only with c_we=1)
- c_op  in  4  ALU op for RMW (ADD 0000 … THB 1111)
- c_addr  in  AW  core address
- c_wdata  in  DW  store data / RMW operand b
- stall  out  1  core must hold PC and request this cycle
- c_rvalid  out  1  c_rdata valid (load completes)
- c_rdata  out  DW  load data
- x_req, x_we  in  1  external request / write
- x_addr  in  AW; x_wdata  in  DW
- x_gnt  out  1  external request accepted this cycle
- x_rvalid  out  1; x_rdata  out  DW  external read data
- m_we  out  1; m_addr  out  AW; m_wdata  out  DW  memory port
- m_rdata  in  DW  memory read data, valid cycle after address
- al_a, al_b  out  DW; al_op  out  4  ALU operands for RMW
- al_y  in  DW  ALU result (combinational)

## Operation
- States: IDLE, CRD (core load data), CRMW (core RMW write-back), XRD (external read data).
- IDLE, grant: external wins if x_req and xwait==XMAX; else core wins if c_req; else external if x_req.
- Core store (c_we=1, c_rmw=0): m_we=1 same cycle, stall=0, stay IDLE.
- Core load: m_addr=c_addr, stall=1, go CRD. CRD: c_rvalid=1, c_rdata=m_rdata, stall=0, go IDLE; no new grant in CRD.
- Core RMW: read c_addr, stall=1, go CRMW. CRMW: al_a=m_rdata, al_b=c_wdata, al_op=c_op, m_we=1, m_addr=c_addr, m_wdata=al_y, stall=0, go IDLE.
- Core request not granted (external wins): stall=1, request retried next cycle.
- External write: x_gnt=1, m_we=1, stay IDLE. External read: x_gnt=1, go XRD; XRD: x_rvalid=1, x_rdata=m_rdata, go IDLE; core stall=1 if c_req in XRD.
- xwait: +1 per cycle x_req=1 and x_gnt=0, saturates at XMAX; cleared on x_gnt.
- c_rmw with c_we=0 is a plain load.
- al_a/al_b/al_op are 0/0/THB outside CRMW.

## Timing
- Reset values: state IDLE, xwait 0, stall 0, c_rvalid 0, x_gnt 0, x_rvalid 0, m_we 0, m_addr 0, m_wdata 0.
- rst during CRD/CRMW/XRD: abort, no write-back, no rvalid next cycle.
- stall, x_gnt, m_* are combinational from state and requests; state/xwait registered.
- Latencies: store 1 cycle; load and RMW 2 cycles (stall high first cycle only); external read data 1 cycle after x_gnt.
- Simultaneous c_req and x_req in IDLE with xwait<XMAX: core served, xwait increments.
- Only one memory access per cycle; never m_we and a read address for different masters in one cycle.

## Configuration
- DMEM_RMW_EN defined: RMW sequence as above, CRMW state present.
- Undefined: c_rmw ignored; RMW store behaves as plain store of c_wdata (SM [ra]=rb), al_* tied to 0/0/THB, CRMW state removed.

## Test plan
- Core store addr 0x10 data 0x1234, then load 0x10 -> m_we pulse 1 cycle; load stall 1 cycle, c_rvalid with c_rdata=0x1234.
- RMW ADD addr 0x20 holding 0x0005, c_wdata 0x0003 -> stall 1 cycle, write of 0x0008 to 0x20 in second cycle; without DMEM_RMW_EN 0x0003 written.
- Core issuing loads continuously with x_req held, XMAX=4 -> x_gnt after xwait reaches 4; core stalled that cycle; xwait returns 0.
- External write 0x30=0xBEEF while core idle, then external read 0x30 -> x_gnt both; x_rvalid x_rdata=0xBEEF next cycle.
- rst asserted in CRMW cycle -> no m_we, all outputs reset values next cycle, memory at addr unchanged.
- Simultaneous core store and x_req with xwait=0 -> core write takes port, x_gnt=0, xwait=1.
